// File: rtl/port_req_ctrl_pkg.sv
// rtl/port_req_ctrl_pkg.sv - shared widths and FSM encoding for the port request controller
package port_req_ctrl_pkg;

  localparam int PORT       = 4;
  localparam int PORTS_DEF  = PORT + 1;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

endpackage

// File: rtl/req_wait_cnt.sv
// rtl/req_wait_cnt.sv - saturating grant-wait counter with clear and registered saturation flag
module req_wait_cnt #(
  parameter int WAIT_W = 8
) (
  input  logic clk,
  input  logic rst_,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_nxt;

  // clear has priority so a transfer on a waiting cycle never counts
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= (cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: rtl/port_req_ctrl.sv
// rtl/port_req_ctrl.sv - input-port requester: raises req to the destination arbiter and streams flits on grant
module port_req_ctrl
  import port_req_ctrl_pkg::*;
#(
  parameter int PORTS  = PORTS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_head,
  input  logic              in_tail,
  input  logic [PORTS-1:0]  in_dst,
  output logic              in_ready,
  output logic [PORTS-1:0]  req,
  input  logic [PORTS-1:0]  grt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tail,
  output logic [PORTS-1:0]  out_sel,
  input  logic              out_ready,
  output logic              err,
  output logic              starve
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PORTS-1:0] dst_r;
  logic [PORTS-1:0] dst_nxt;
  logic [PORTS-1:0] req_nxt;
  logic             active;
  logic             hit;
  logic             xfer;
  logic             dst_ok;
  logic             ready_c;
  logic             err_c;

  assign active = (state == ST_ACTIVE);
  assign hit    = active && |(grt & dst_r);
  assign xfer   = hit && in_valid && out_ready;
  assign dst_ok = (in_dst != '0) && ((in_dst & (in_dst - PORTS'(1))) == '0);

  always_comb begin
    state_nxt = state;
    dst_nxt   = dst_r;
    req_nxt   = req;
    ready_c   = 1'b0;
    err_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_head && dst_ok) begin
            // head stays in the buffer; it goes out once the grant arrives
            state_nxt = ST_ACTIVE;
            dst_nxt   = in_dst;
            req_nxt   = in_dst;
          end else begin
            ready_c = 1'b1;
            err_c   = 1'b1;
            if (in_head && !in_tail) begin
              state_nxt = ST_DROP;
            end
          end
        end
      end
      ST_ACTIVE: begin
        ready_c = xfer;
        if (xfer && in_tail) begin
          state_nxt = ST_IDLE;
          req_nxt   = '0;
        end
      end
      ST_DROP: begin
        ready_c = in_valid;
        if (in_valid && in_tail) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      dst_r <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      dst_r <= dst_nxt;
      req   <= req_nxt;
    end
  end

  // pops and error pulses are suppressed while reset is held
  assign in_ready  = rst_ && ready_c;
  assign err       = rst_ && err_c;
  assign out_valid = hit && in_valid;
  assign out_data  = active ? in_data : '0;
  assign out_tail  = active && in_tail;
  assign out_sel   = hit ? dst_r : '0;

  req_wait_cnt #(
    .WAIT_W (WAIT_W)
  ) u_wait_cnt (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (!active || xfer),
    .inc  (active && in_valid && !hit),
    .sat  (starve)
  );

endmodule

// File: tb/tb_port_req_ctrl.sv
// tb/tb_port_req_ctrl.sv - self-checking bench for port_req_ctrl: vector table, directed corners, randomized scoreboard
module tb_port_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_head;
  logic        in_tail;
  logic [4:0]  in_dst;
  logic        in_ready;
  logic [4:0]  req;
  logic [4:0]  grt;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_tail;
  logic [4:0]  out_sel;
  logic        out_ready;
  logic        err;
  logic        starve;
  logic [4:0]  gmask;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // single-requester arbiter: grant follows req unless masked off
  assign grt = req & gmask;

  port_req_ctrl #(.PORTS(5), .DATA_W(32), .WAIT_W(3)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data), .in_head(in_head),
    .in_tail(in_tail), .in_dst(in_dst), .in_ready(in_ready), .req(req), .grt(grt),
    .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail), .out_sel(out_sel),
    .out_ready(out_ready), .err(err), .starve(starve)
  );

  typedef struct {
    logic v, h, t; logic [4:0] dst; logic [4:0] gm; logic ordy;
    logic e_rdy; logic [4:0] e_req; logic e_ov; logic [4:0] e_sel; logic e_err;
  } vec_t;
  vec_t tbl [0:21];

  typedef struct { logic [31:0] d; logic h, t; logic [4:0] dst; } flit_t;
  typedef struct { logic [31:0] d; logic t; logic [4:0] sel; } xo_t;
  flit_t src[$];
  xo_t   exp_q[$];
  logic [31:0] got[$];

  flit_t fl;
  xo_t   eo;
  int    xf, hold, cyc, len, bad_pkts, err_seen, a;
  logic  good;
  logic [4:0] dst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic t, input logic [4:0] d, input logic [31:0] dat);
    in_valid = v; in_head = h; in_tail = t; in_dst = d; in_data = dat;
  endtask

  initial begin
    rst_ = 1'b0; gmask = 5'h1F; out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'h00, 32'h1234);
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_req", req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_starve", starve, 0);
    tick; tick;
    rst_ = 1'b1;

    // v h t dst gm ordy | rdy req ov sel err
    tbl[0]  = '{0,0,0,5'h00,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[1]  = '{1,1,1,5'h04,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[2]  = '{1,1,1,5'h04,5'h1F,1, 1,5'h04,1,5'h04,0};
    tbl[3]  = '{0,0,0,5'h00,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[4]  = '{1,1,0,5'h00,5'h1F,1, 1,5'h00,0,5'h00,1};
    tbl[5]  = '{1,0,0,5'h00,5'h1F,1, 1,5'h00,0,5'h00,0};
    tbl[6]  = '{1,0,0,5'h00,5'h1F,1, 1,5'h00,0,5'h00,0};
    tbl[7]  = '{1,0,1,5'h00,5'h1F,1, 1,5'h00,0,5'h00,0};
    tbl[8]  = '{1,1,1,5'h03,5'h1F,1, 1,5'h00,0,5'h00,1};
    tbl[9]  = '{1,0,0,5'h00,5'h1F,1, 1,5'h00,0,5'h00,1};
    tbl[10] = '{1,1,0,5'h01,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[11] = '{1,1,0,5'h01,5'h1F,1, 1,5'h01,1,5'h01,0};
    tbl[12] = '{1,0,1,5'h00,5'h1F,1, 1,5'h01,1,5'h01,0};
    tbl[13] = '{1,1,1,5'h01,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[14] = '{1,1,1,5'h01,5'h1F,1, 1,5'h01,1,5'h01,0};
    tbl[15] = '{1,1,0,5'h02,5'h1F,1, 0,5'h00,0,5'h00,0};
    tbl[16] = '{1,1,0,5'h02,5'h00,1, 0,5'h02,0,5'h00,0};
    tbl[17] = '{1,1,0,5'h02,5'h1F,0, 0,5'h02,1,5'h02,0};
    tbl[18] = '{1,1,0,5'h02,5'h1F,1, 1,5'h02,1,5'h02,0};
    tbl[19] = '{1,1,0,5'h00,5'h1F,1, 1,5'h02,1,5'h02,0};
    tbl[20] = '{1,0,1,5'h00,5'h1F,1, 1,5'h02,1,5'h02,0};
    tbl[21] = '{0,0,0,5'h00,5'h1F,1, 0,5'h00,0,5'h00,0};

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].dst, 32'hA000_0000 + i);
      gmask = tbl[i].gm; out_ready = tbl[i].ordy;
      #3;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_out_sel", i), out_sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_data", i), out_data, 32'hA000_0000 + i);
        chk($sformatf("tbl%0d_out_tail", i), out_tail, tbl[i].t);
      end
      tick;
    end
    gmask = 5'h1F; out_ready = 1'b1;

    // 4-flit packet to port 1, grant withheld for 3 cycles after two transfers
    xf = 0; hold = 0;
    for (cyc = 0; cyc < 30 && xf < 4; cyc++) begin
      drive(1'b1, xf == 0, xf == 3, 5'h02, 32'hB0 + xf);
      gmask = (xf == 2 && hold < 3) ? 5'h00 : 5'h1F;
      #3;
      if (cyc > 0) chk("gw_req_held", req, 5'h02);
      if (gmask == 5'h00) begin
        hold++;
        chk("gw_stall", in_ready, 0);
      end
      if (in_ready) begin
        got.push_back(out_data);
        xf++;
      end
      tick;
    end
    chk("gw_xfers", xf, 4);
    chk("gw_hold_cycles", hold, 3);
    for (int i = 0; i < 4; i++) chk($sformatf("gw_order%0d", i), (i < got.size()) ? got[i] : 32'hDEAD, 32'hB0 + i);
    drive(1'b0, 1'b0, 1'b0, 5'h00, 32'h0); gmask = 5'h1F;
    #3;
    chk("gw_req_drop", req, 0);
    tick;

    // starvation: no grant for 9 cycles, grant on the 10th
    drive(1'b1, 1'b1, 1'b1, 5'h08, 32'hC0); gmask = 5'h00;
    #3; tick;
    for (int k = 1; k <= 10; k++) begin
      gmask = (k == 10) ? 5'h1F : 5'h00;
      #3;
      chk($sformatf("starve_k%0d", k), starve, k >= 8);
      if (k == 10) chk("starve_xfer", in_ready, 1);
      tick;
    end
    drive(1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
    #3;
    chk("starve_clear", starve, 0);
    tick;

    // reset after 2 of 4 flits; the rest arrive headless and are dropped
    gmask = 5'h1F;
    drive(1'b1, 1'b1, 1'b0, 5'h04, 32'hD0); #3; tick;
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, f == 0, 1'b0, 5'h04, 32'hD0 + f);
      #3;
      chk("rp_xfer", in_ready, 1);
      tick;
    end
    drive(1'b1, 1'b0, 1'b0, 5'h04, 32'hD2);
    rst_ = 1'b0;
    #3;
    chk("rp_rst_in_ready", in_ready, 0);
    chk("rp_rst_req", req, 0);
    chk("rp_rst_out_valid", out_valid, 0);
    chk("rp_rst_out_sel", out_sel, 0);
    chk("rp_rst_out_data", out_data, 0);
    chk("rp_rst_err", err, 0);
    tick; tick;
    rst_ = 1'b1;
    #3;
    chk("rp_drop2_rdy", in_ready, 1);
    chk("rp_drop2_err", err, 1);
    tick;
    drive(1'b1, 1'b0, 1'b1, 5'h04, 32'hD3);
    #3;
    chk("rp_drop3_rdy", in_ready, 1);
    chk("rp_drop3_err", err, 1);
    tick;
    drive(1'b1, 1'b1, 1'b1, 5'h01, 32'hE0);
    #3;
    chk("rp_new_wait", in_ready, 0);
    tick;
    #3;
    chk("rp_new_req", req, 5'h01);
    chk("rp_new_xfer", in_ready && out_valid, 1);
    chk("rp_new_err", err, 0);
    tick;

    // randomized packets against a flit-order scoreboard
    bad_pkts = 0; err_seen = 0;
    for (int p = 0; p < 60; p++) begin
      len  = $urandom_range(1, 4);
      good = ($urandom % 4) != 0;
      a    = $urandom_range(0, 4);
      if (good) dst = 5'b1 << a;
      else if ($urandom % 2) dst = 5'h00;
      else dst = (5'b1 << a) | (5'b1 << ((a + 1 + $urandom_range(0, 3)) % 5));
      if (!good) bad_pkts++;
      for (int f = 0; f < len; f++) begin
        fl.d = $urandom; fl.h = (f == 0); fl.t = (f == len - 1);
        fl.dst = (f == 0) ? dst : 5'($urandom);
        src.push_back(fl);
        if (good) begin
          eo.d = fl.d; eo.t = fl.t; eo.sel = dst;
          exp_q.push_back(eo);
        end
      end
    end
    cyc = 0;
    while (src.size() > 0 && cyc < 5000) begin
      if (($urandom % 4) != 0) drive(1'b1, src[0].h, src[0].t, src[0].dst, src[0].d);
      else drive(1'b0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
      gmask = (($urandom % 4) != 0) ? 5'h1F : 5'($urandom);
      out_ready = ($urandom % 4) != 0;
      #3;
      if (err) err_seen++;
      if (out_valid) chk("rnd_err_in_active", err, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_extra_flit", 1, 0);
        else begin
          eo = exp_q.pop_front();
          chk("rnd_data", out_data, eo.d);
          chk("rnd_tail", out_tail, eo.t);
          chk("rnd_sel", out_sel, eo.sel);
          chk("rnd_req", req, eo.sel);
          chk("rnd_pop", in_ready, 1);
        end
      end
      if (in_valid && in_ready) void'(src.pop_front());
      tick;
      cyc++;
    end
    chk("rnd_drained", src.size(), 0);
    chk("rnd_exp_left", exp_q.size(), 0);
    chk("rnd_err_count", err_seen, bad_pkts);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
